q_inv_lookup: RTL and testbench



---
 rtl/q_lookup_pkg.sv | 39 +++
 rtl/q_table_rd.sv | 15 +
 rtl/q_inv_lookup.sv | 124 ++++++++++++
 tb/tb_q_inv_lookup.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/q_lookup_pkg.sv
// Shared constants, FSM state type and the reciprocal Q table contents
// for the inverse-lookup block and its table reader.
package q_lookup_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int ITERS  = 4;
  localparam int CNT_W  = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2
  } state_t;

  // Monotonically decreasing reciprocal table; unused addresses read as 0.
  function automatic logic [DATA_W-1:0] q_entry(input logic [ADDR_W-1:0] addr);
    case (addr)
      4'd0:    q_entry = 16'd255;
      4'd1:    q_entry = 16'd128;
      4'd2:    q_entry = 16'd85;
      4'd3:    q_entry = 16'd64;
      4'd4:    q_entry = 16'd51;
      4'd5:    q_entry = 16'd42;
      4'd6:    q_entry = 16'd36;
      4'd7:    q_entry = 16'd32;
      4'd8:    q_entry = 16'd28;
      4'd9:    q_entry = 16'd25;
      4'd10:   q_entry = 16'd23;
      4'd11:   q_entry = 16'd21;
      default: q_entry = '0;
    endcase
  endfunction

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] Q_LAST    = q_entry(LAST_ADDR);

endpackage

// File: rtl/q_table_rd.sv
// Combinational read port on the reciprocal Q table.
// Addresses at or beyond DEPTH return 0.
module q_table_rd
  import q_lookup_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    if (addr < ADDR_W'(DEPTH)) data = q_entry(addr);
  end

endmodule

// File: rtl/q_inv_lookup.sv
// Reverse lookup on the Q table: fixed-latency binary search for the smallest
// address whose entry is <= target. Define Q_LOOKUP_NEAREST_EN to pick the nearest entry.
module q_inv_lookup
  import q_lookup_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] index,
  output logic              exact,
  output logic              out_of_range
);

  // Handshake: start is sampled only in IDLE; the accepting edge captures
  // target and raises busy. Exactly ITERS+1 edges later done pulses for one
  // cycle with busy low, and a new start may be accepted in that same cycle.
  // start while busy is dropped, not queued.

  state_t              state, state_nx;
  logic [CNT_W-1:0]    step;
  logic [ADDR_W-1:0]   lo, hi, lo_nx, hi_nx, mid, rd_addr, idx_nx;
  logic [DATA_W-1:0]   tgt, rd_data;
  logic                accept, step_en, finish;
  logic                hit_nx, oor_nx;

  q_table_rd u_rd_main (
    .addr (rd_addr),
    .data (rd_data)
  );

`ifdef Q_LOOKUP_NEAREST_EN
  logic [DATA_W-1:0] prev_data;

  q_table_rd u_rd_prev (
    .addr (lo - 1'b1),
    .data (prev_data)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SEARCH;
      SEARCH:  if (step == CNT_W'(ITERS - 1)) state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept  = (state == IDLE) && start;
    step_en = (state == SEARCH);
    finish  = (state == CHECK);
  end

  // One shared table read: the probe at mid while searching, table[lo] when checking.
  always_comb begin
    mid     = ADDR_W'(({1'b0, lo} + {1'b0, hi}) >> 1);
    rd_addr = (state == SEARCH) ? mid : lo;
    lo_nx   = lo;
    hi_nx   = hi;
    if (lo < hi) begin
      if (rd_data <= tgt) hi_nx = mid;
      else                lo_nx = mid + 1'b1;
    end
    oor_nx = (tgt < Q_LAST);
    idx_nx = lo;
    hit_nx = (rd_data == tgt);
`ifdef Q_LOOKUP_NEAREST_EN
    if (!oor_nx && (lo != '0) && ((prev_data - tgt) < (tgt - rd_data))) begin
      idx_nx = lo - 1'b1;
      hit_nx = (prev_data == tgt);
    end
`endif
    if (oor_nx) begin
      idx_nx = LAST_ADDR;
      hit_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt          <= '0;
      lo           <= '0;
      hi           <= '0;
      step         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      index        <= '0;
      exact        <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tgt  <= target;
        lo   <= '0;
        hi   <= LAST_ADDR;
        step <= '0;
        busy <= 1'b1;
      end
      if (step_en) begin
        lo   <= lo_nx;
        hi   <= hi_nx;
        step <= step + 1'b1;
      end
      if (finish) begin
        index        <= idx_nx;
        exact        <= hit_nx;
        out_of_range <= oor_nx;
        done         <= 1'b1;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_q_inv_lookup.sv
// Bench for q_inv_lookup: directed vector table, busy/reset corner sequences,
// and random targets against a linear-scan reference model.
module tb_q_inv_lookup;
  import q_lookup_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] target;
  logic              busy, done, exact, out_of_range;
  logic [ADDR_W-1:0] index;

  int errors = 0;
  int checks = 0;

  int q_tab[12] = '{255, 128, 85, 64, 51, 42, 36, 32, 28, 25, 23, 21};

  typedef struct {
    int tgt;
    int idx;
    int ex;
    int oor;
  } vec_t;

  vec_t vecs[$];

  q_inv_lookup dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .target       (target),
    .busy         (busy),
    .done         (done),
    .index        (index),
    .exact        (exact),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nf(input int floor_v, input int near_v);
`ifdef Q_LOOKUP_NEAREST_EN
    return near_v;
`else
    return floor_v;
`endif
  endfunction

  // Reference: linear scan for the first entry not above t, then optional nearest adjust.
  function automatic void ref_lookup(input int t, output int idx, output int ex, output int oor);
    idx = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_tab[i] <= t) begin
        idx = i;
        break;
      end
    end
    oor = (idx < 0) ? 1 : 0;
    if (oor == 1) idx = DEPTH - 1;
`ifdef Q_LOOKUP_NEAREST_EN
    if (oor == 0 && idx > 0 && (q_tab[idx-1] - t) < (t - q_tab[idx])) idx = idx - 1;
`endif
    ex = (q_tab[idx] == t) ? 1 : 0;
  endfunction

  task automatic launch(input logic [DATA_W-1:0] t);
    start  = 1'b1;
    target = t;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic expect_model(input string name, input int t);
    int ri, re, ro;
    ref_lookup(t, ri, re, ro);
    check({name, "_index"}, index, ri);
    check({name, "_exact"}, exact, re);
    check({name, "_oor"}, out_of_range, ro);
    check({name, "_busy_low"}, busy, 0);
  endtask

  task automatic run_one(input string name, input int t);
    int lat;
    launch(DATA_W'(t));
    wait_done(lat);
    check({name, "_latency"}, lat, 5);
    expect_model(name, t);
  endtask

  initial begin
    int lat, dones, t;

    // Reset with start held high: everything stays at zero.
    rst_n  = 1'b0;
    start  = 1'b1;
    target = 16'd64;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", index, 0);
    check("rst_exact", exact, 0);
    check("rst_oor", out_of_range, 0);
    start = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived expectations.
    vecs.push_back('{64,    3,           1, 0});
    vecs.push_back('{30,    8,           0, 0});
    vecs.push_back('{10,    11,          0, 1});
    vecs.push_back('{65535, 0,           0, 0});
    vecs.push_back('{255,   0,           1, 0});
    vecs.push_back('{21,    11,          1, 0});
    vecs.push_back('{20,    11,          0, 1});
    vecs.push_back('{0,     11,          0, 1});
    vecs.push_back('{128,   1,           1, 0});
    vecs.push_back('{86,    2,           0, 0});
    vecs.push_back('{31,    nf(8, 7),    0, 0});
    vecs.push_back('{127,   nf(2, 1),    0, 0});
    vecs.push_back('{200,   nf(1, 0),    0, 0});
    vecs.push_back('{33,    nf(7, 7),    0, 0});
    foreach (vecs[i]) begin
      launch(DATA_W'(vecs[i].tgt));
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_index", i), index, vecs[i].idx);
      check($sformatf("vec%0d_exact", i), exact, vecs[i].ex);
      check($sformatf("vec%0d_oor", i), out_of_range, vecs[i].oor);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // start held and target churned while busy: result follows the captured value.
    launch(16'd64);
    dones = 0;
    for (int k = 1; k <= 5; k++) begin
      start  = 1'b1;
      target = DATA_W'($urandom_range(0, 65535));
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("busy_ignore_one_done", dones, 1);
    check("busy_ignore_done_now", done, 1);
    expect_model("busy_ignore", 64);
    // New request accepted in the done cycle.
    target = 16'd30;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_cleared", done, 0);
    wait_done(lat);
    check("b2b_latency", lat, 5);
    expect_model("b2b", 30);

    // Reset mid-search aborts without a done pulse.
    run_one("pre_abort", 64);
    launch(16'd30);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_index", index, 0);
    check("abort_exact", exact, 0);
    check("abort_oor", out_of_range, 0);
    #3 rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_one("post_abort", 21);

    // Random targets, biased half toward the table's own range.
    for (int i = 0; i < 60; i++) begin
      t = (i % 2 == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 65535));
      run_one($sformatf("rand%0d", i), t);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
